// File: rtl/debug_uart_tx_scheduler.sv
// Debug UART transmit scheduler: decodes command bytes, snapshots status
// channels into 4-byte framed packets and drives the transmitter byte handshake.
module debug_uart_tx_scheduler #(
  parameter int         N_CH        = 8,
  parameter int         PERIOD_CLKS = 1000000,
  parameter logic [7:0] HDR_BYTE    = 8'hD5
) (
  input  logic                clk_uart,
  input  logic                rstn,
  input  logic [8*N_CH-1:0]   in_status,
  input  logic                in_rx_dv,
  input  logic [7:0]          in_rx_byte,
  output logic                out_tx_dv,
  output logic [7:0]          out_tx_byte,
  input  logic                in_tx_active,
  input  logic                in_tx_done,
  output logic                out_busy,
  output logic                out_cmd_err,
  output logic [15:0]         out_frame_cnt
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TMR_W = $clog2(PERIOD_CLKS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD_CLKS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

  localparam logic [7:0] CMD_DUMP    = 8'hA5;
  localparam logic [7:0] CMD_PER_ON  = 8'h5A;
  localparam logic [7:0] CMD_PER_OFF = 8'hC3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_NEXT
  } state_t;

  state_t           r_state;
  logic             r_pend_single;
  logic [CH_W-1:0]  r_pend_idx;
  logic             r_pend_dump;
  logic             r_per_en;
  logic [TMR_W-1:0] r_timer;
  logic [CH_W-1:0]  r_ch;
  logic             r_dump_mode;
  logic [1:0]       r_byte_idx;
  logic [3:0][7:0]  r_frame;
  logic             r_tx_dv;
  logic [7:0]       r_tx_byte;
  logic             r_cmd_err;
  logic [15:0]      r_frame_cnt;

  logic             w_cmd_single;
  logic             w_cmd_dump;
  logic             w_cmd_per_on;
  logic             w_cmd_per_off;
  logic             w_cmd_bad;
  logic             w_tmr_hit;
  logic             w_take_single;
  logic             w_take_dump;
  logic [7:0]       w_snap;
  logic [7:0]       w_ch_byte;

  // Command decode; channel indices never collide with the fixed opcodes.
  always_comb begin
    w_cmd_single  = in_rx_dv && (in_rx_byte < 8'(N_CH));
    w_cmd_dump    = in_rx_dv && (in_rx_byte == CMD_DUMP);
    w_cmd_per_on  = in_rx_dv && (in_rx_byte == CMD_PER_ON);
    w_cmd_per_off = in_rx_dv && (in_rx_byte == CMD_PER_OFF);
    w_cmd_bad     = in_rx_dv && !(w_cmd_single || w_cmd_dump ||
                                  w_cmd_per_on || w_cmd_per_off);
  end

  assign w_tmr_hit     = r_per_en && (r_timer == TMR_LAST);
  assign w_take_single = (r_state == S_IDLE) && r_pend_single;
  assign w_take_dump   = (r_state == S_IDLE) && !r_pend_single && r_pend_dump;
  assign w_ch_byte     = 8'(r_ch);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_snap = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (r_ch == CH_W'(k)) w_snap = in_status[8*k +: 8];
    end
  end

  // Request flags: a new request in the same cycle as the FSM consumes the
  // old one wins, so nothing arriving on that edge is lost.
  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // update together from pre-edge values regardless of statement order.
  always_ff @(posedge clk_uart or negedge rstn) begin
    if (!rstn) begin
      r_pend_single <= 1'b0;
      r_pend_idx    <= '0;
      r_pend_dump   <= 1'b0;
      r_per_en      <= 1'b0;
      r_timer       <= '0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_cmd_err <= w_cmd_bad;

      if (w_cmd_single) begin
        r_pend_single <= 1'b1;
        r_pend_idx    <= in_rx_byte[CH_W-1:0];
      end else if (w_take_single) begin
        r_pend_single <= 1'b0;
      end

      if (w_cmd_dump || w_tmr_hit) begin
        r_pend_dump <= 1'b1;
      end else if (w_take_dump) begin
        r_pend_dump <= 1'b0;
      end

      if (w_cmd_per_on) begin
        r_per_en <= 1'b1;
        r_timer  <= '0;
      end else if (w_cmd_per_off) begin
        r_per_en <= 1'b0;
        r_timer  <= '0;
      end else if (r_per_en) begin
        r_timer <= w_tmr_hit ? '0 : r_timer + 1'b1;
      end
    end
  end

  // NOTE: the 4-byte frame buffer is reset along with the control state; it is
  // small, and a clean reset keeps out_tx_byte at 0 until the first frame.
  always_ff @(posedge clk_uart or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_dump_mode <= 1'b0;
      r_byte_idx  <= '0;
      r_frame     <= '0;
      r_tx_dv     <= 1'b0;
      r_tx_byte   <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_tx_dv <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (r_pend_single) begin
            r_ch        <= r_pend_idx;
            r_dump_mode <= 1'b0;
            r_state     <= S_LOAD;
          end else if (r_pend_dump) begin
            r_ch        <= '0;
            r_dump_mode <= 1'b1;
            r_state     <= S_LOAD;
          end
        end

        // Status is captured here so the frame in flight stays self-consistent.
        S_LOAD: begin
          r_frame[0] <= HDR_BYTE;
          r_frame[1] <= w_ch_byte;
          r_frame[2] <= w_snap;
          r_frame[3] <= HDR_BYTE ^ w_ch_byte ^ w_snap;
          r_byte_idx <= '0;
          r_state    <= S_SEND;
        end

        S_SEND: begin
          if (!in_tx_active) begin
            r_tx_dv   <= 1'b1;
            r_tx_byte <= r_frame[r_byte_idx];
            r_state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (in_tx_done) begin
            if (r_byte_idx != 2'd3) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_state    <= S_SEND;
            end else begin
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_state     <= S_NEXT;
            end
          end
        end

        S_NEXT: begin
          if (r_dump_mode && (r_ch != CH_LAST)) begin
            r_ch    <= r_ch + 1'b1;
            r_state <= S_LOAD;
          end else begin
            r_dump_mode <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_tx_dv     = r_tx_dv;
  assign out_tx_byte   = r_tx_byte;
  assign out_busy      = (r_state != S_IDLE);
  assign out_cmd_err   = r_cmd_err;
  assign out_frame_cnt = r_frame_cnt;

endmodule
